// File: rtl/regfile_mp_if.sv
// Bundles the read/write/clear signals between the pipeline and regfile_mp.
// The master drives addresses, write data and clear requests; the slave is the register file.
interface regfile_mp_if #(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                     clear_req;
  logic                     busy;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic                     wr_ignored;
  logic [NUM_RD*AW-1:0]     raddr;
  logic [NUM_RD*XLEN-1:0]   rdata;

  modport master (
    output clear_req, we, waddr, wdata, raddr,
    input  busy, wr_ignored, rdata
  );

  modport slave (
    input  clear_req, we, waddr, wdata, raddr,
    output busy, wr_ignored, rdata
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with registered reads, write bypass,
// optional hardwired zero register and a one-entry-per-cycle clear engine.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [XLEN-1:0]        mem [DEPTH];
  logic                   wr_ok;
  logic [XLEN-1:0]        rd_d [NUM_RD];
  logic [NUM_RD*XLEN-1:0] rdata_q;
  logic                   wr_ign_q;

  // Clear requests take priority over a write in the same cycle.
  always_comb begin
    wr_ok = 1'b0;
    if (state_q == S_IDLE && !bus.clear_req && bus.we &&
        ({1'b0, bus.waddr} < DEPTH_W))
      wr_ok = !(ZERO_REG != 0 && bus.waddr == '0);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_CLEAR: begin
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_d[k] = '0;
      if (state_q == S_IDLE &&
          ({1'b0, bus.raddr[k*AW +: AW]} < DEPTH_W) &&
          !(ZERO_REG != 0 && bus.raddr[k*AW +: AW] == '0)) begin
        if (BYPASS != 0 && wr_ok && bus.waddr == bus.raddr[k*AW +: AW])
          rd_d[k] = bus.wdata;
        else
          rd_d[k] = mem[bus.raddr[k*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CLEAR;
      idx_q    <= '0;
      rdata_q  <= '0;
      wr_ign_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ign_q <= bus.we && !wr_ok;
      for (int k = 0; k < NUM_RD; k++)
        rdata_q[k*XLEN +: XLEN] <= rd_d[k];
    end
  end

  // The array has no reset; the clear engine zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR)
      mem[idx_q] <= '0;
    else if (wr_ok)
      mem[bus.waddr] <= bus.wdata;
  end

  assign bus.busy       = (state_q == S_CLEAR);
  assign bus.wr_ignored = wr_ign_q;
  assign bus.rdata      = rdata_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config, a no-bypass copy and a 24-entry
// three-port copy, each checked against hand-computed values.
module tb_regfile_mp;
  logic clk;
  logic reset_ab;
  logic reset_c;
  int   checkCount;
  int   passCount;
  int   edges;

  regfile_mp_if #(.XLEN(64), .DEPTH(32), .NUM_RD(2)) bus_a();
  regfile_mp_if #(.XLEN(64), .DEPTH(32), .NUM_RD(2)) bus_b();
  regfile_mp_if #(.XLEN(64), .DEPTH(24), .NUM_RD(3)) bus_c();

  regfile_mp #(.XLEN(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    u_a (.clk(clk), .reset(reset_ab), .bus(bus_a));
  regfile_mp #(.XLEN(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
    u_b (.clk(clk), .reset(reset_ab), .bus(bus_b));
  regfile_mp #(.XLEN(64), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1))
    u_c (.clk(clk), .reset(reset_c), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus goes to the bypass and no-bypass copies, then one edge passes.
  task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic [63:0] wdata,
                               input logic [4:0] ra0, input logic [4:0] ra1, input logic clr);
    bus_a.we = we; bus_a.waddr = waddr; bus_a.wdata = wdata;
    bus_a.raddr = {ra1, ra0}; bus_a.clear_req = clr;
    bus_b.we = we; bus_b.waddr = waddr; bus_b.wdata = wdata;
    bus_b.raddr = {ra1, ra0}; bus_b.clear_req = clr;
    tick();
  endtask

  task automatic applyC(input logic we, input logic [4:0] waddr, input logic [63:0] wdata,
                        input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic clr);
    bus_c.we = we; bus_c.waddr = waddr; bus_c.wdata = wdata;
    bus_c.raddr = {ra2, ra1, ra0}; bus_c.clear_req = clr;
    tick();
  endtask

  task automatic waitIdle(input int which, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((which == 0) ? bus_a.busy : bus_c.busy) && n < 200);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset_ab   = 1'b0;
    reset_c    = 1'b0;
    bus_a.we = 0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.raddr = '0; bus_a.clear_req = 0;
    bus_b.we = 0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.raddr = '0; bus_b.clear_req = 0;
    bus_c.we = 0; bus_c.waddr = '0; bus_c.wdata = '0; bus_c.raddr = '0; bus_c.clear_req = 0;
    #3;
    checkOutput("rst busy", {63'b0, bus_a.busy}, 64'd1);
    checkOutput("rst wr_ignored", {63'b0, bus_a.wr_ignored}, 64'd0);
    checkOutput("rst rdata", {63'b0, |bus_a.rdata}, 64'd0);

    @(negedge clk);
    reset_ab = 1'b1;
    waitIdle(0, edges);
    checkOutput("clear cycles", 64'(edges), 64'd32);
    checkOutput("b idle", {63'b0, bus_b.busy}, 64'd0);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 5'd0, 64'd0, 5'(i), 5'(31 - i), 0);
      checkOutput("sweep p0", bus_a.rdata[63:0], 64'd0);
      checkOutput("sweep p1", bus_a.rdata[127:64], 64'd0);
    end

    applyStimulus(1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd0, 5'd0, 0);
    checkOutput("wr5 ignored", {63'b0, bus_a.wr_ignored}, 64'd0);
    applyStimulus(0, 5'd0, 64'd0, 5'd5, 5'd5, 0);
    checkOutput("rd5 p0", bus_a.rdata[63:0], 64'hDEADBEEF_CAFEF00D);
    checkOutput("rd5 p1", bus_a.rdata[127:64], 64'hDEADBEEF_CAFEF00D);
    checkOutput("rd5 b p1", bus_b.rdata[127:64], 64'hDEADBEEF_CAFEF00D);

    applyStimulus(1, 5'd7, 64'h55, 5'd0, 5'd0, 0);
    applyStimulus(1, 5'd7, 64'h1234, 5'd7, 5'd6, 0);
    checkOutput("bypass a", bus_a.rdata[63:0], 64'h1234);
    checkOutput("bypass b old", bus_b.rdata[63:0], 64'h55);
    checkOutput("bypass other port", bus_a.rdata[127:64], 64'd0);
    applyStimulus(0, 5'd0, 64'd0, 5'd7, 5'd7, 0);
    checkOutput("no-bypass later p0", bus_b.rdata[63:0], 64'h1234);
    checkOutput("no-bypass later p1", bus_b.rdata[127:64], 64'h1234);

    applyStimulus(1, 5'd0, 64'hFF, 5'd0, 5'd5, 0);
    checkOutput("zero wr ignored", {63'b0, bus_a.wr_ignored}, 64'd1);
    checkOutput("zero reg bypass", bus_a.rdata[63:0], 64'd0);
    checkOutput("p1 during zero wr", bus_a.rdata[127:64], 64'hDEADBEEF_CAFEF00D);
    applyStimulus(0, 5'd0, 64'd0, 5'd0, 5'd0, 0);
    checkOutput("ignored pulse end", {63'b0, bus_a.wr_ignored}, 64'd0);
    checkOutput("zero reg read", bus_a.rdata[63:0], 64'd0);

    applyStimulus(1, 5'd3, 64'hAA, 5'd0, 5'd0, 0);
    applyStimulus(1, 5'd4, 64'h77, 5'd3, 5'd4, 1);
    checkOutput("clr wr ignored", {63'b0, bus_a.wr_ignored}, 64'd1);
    checkOutput("clr busy", {63'b0, bus_a.busy}, 64'd1);
    checkOutput("clr edge rd3", bus_a.rdata[63:0], 64'hAA);
    checkOutput("clr edge rd4", bus_a.rdata[127:64], 64'd0);
    applyStimulus(1, 5'd4, 64'h77, 5'd3, 5'd4, 0);
    checkOutput("midclr wr ignored", {63'b0, bus_a.wr_ignored}, 64'd1);
    checkOutput("midclr rdata", bus_a.rdata[63:0], 64'd0);
    applyStimulus(0, 5'd0, 64'd0, 5'd3, 5'd4, 0);
    checkOutput("midclr busy", {63'b0, bus_a.busy}, 64'd1);
    waitIdle(0, edges);
    checkOutput("clr remaining cycles", 64'(edges), 64'd30);
    applyStimulus(0, 5'd0, 64'd0, 5'd3, 5'd4, 0);
    checkOutput("post clr rd3", bus_a.rdata[63:0], 64'd0);
    checkOutput("post clr rd4", bus_a.rdata[127:64], 64'd0);
    applyStimulus(0, 5'd0, 64'd0, 5'd5, 5'd7, 0);
    checkOutput("post clr rd5", bus_a.rdata[63:0], 64'd0);
    checkOutput("post clr b rd7", bus_b.rdata[127:64], 64'd0);

    @(negedge clk);
    reset_c = 1'b1;
    waitIdle(1, edges);
    checkOutput("c clear cycles", 64'(edges), 64'd24);
    applyC(1, 5'd23, 64'h99, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("c wr23 ignored", {63'b0, bus_c.wr_ignored}, 64'd0);
    applyC(1, 5'd30, 64'h5, 5'd30, 5'd23, 5'd24, 0);
    checkOutput("c wr30 ignored", {63'b0, bus_c.wr_ignored}, 64'd1);
    checkOutput("c rd30", bus_c.rdata[63:0], 64'd0);
    checkOutput("c rd23", bus_c.rdata[127:64], 64'h99);
    checkOutput("c rd24", bus_c.rdata[191:128], 64'd0);

    applyC(0, 5'd0, 64'd0, 5'd0, 5'd23, 5'd0, 0);
    @(negedge clk);
    reset_c = 1'b0;
    #1;
    checkOutput("c async rdata", bus_c.rdata[127:64], 64'd0);
    checkOutput("c async busy", {63'b0, bus_c.busy}, 64'd1);
    @(negedge clk);
    reset_c = 1'b1;
    waitIdle(1, edges);
    checkOutput("c re-clear cycles", 64'(edges), 64'd24);

    applyC(0, 5'd0, 64'd0, 5'd0, 5'd23, 5'd0, 1);
    bus_c.clear_req = 0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    reset_c = 1'b0;
    #1;
    checkOutput("c midclr rst busy", {63'b0, bus_c.busy}, 64'd1);
    checkOutput("c midclr rst rdata", {63'b0, |bus_c.rdata}, 64'd0);
    @(negedge clk);
    reset_c = 1'b1;
    waitIdle(1, edges);
    checkOutput("c restart cycles", 64'(edges), 64'd24);
    applyC(0, 5'd0, 64'd0, 5'd0, 5'd23, 5'd0, 0);
    checkOutput("c rd23 after clear", bus_c.rdata[127:64], 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
